lsu_param: RTL and testbench
============================

Name: lsu_param

Overview:
- Parametrised next-generation per-thread load/store unit for the GPU cores; one instance per thread lane.
- Executes LDR/STR against the data-memory controller over separate read and write valid/ready channels.
- Generalises address/data width and removes the request bubble (request is issued the cycle after acceptance).
- Adds a response timeout with error flag, a one-cycle completion strobe, and a retire handshake so a held instruction is never re-issued.

Parameters:
- ADDR_WIDTH, 8, memory address width (rs is ADDR_WIDTH bits).
- DATA_WIDTH, 8, memory data width (rt, lsu_out).
- TIMEOUT_CYCLES, 255, max cycles in WAITING before abort; 0 disables timeout.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-low reset: 0 = reset asserted.
- enable  in  1  thread active in current block; inactive lane never starts an op.
- decoded_mem_read_enable  in  1  LDR decoded.
- decoded_mem_write_enable  in  1  STR decoded.
- rs  in  ADDR_WIDTH  address operand.
- rt  in  DATA_WIDTH  store data operand.
- mem_read_valid  out  1  read request.
- mem_read_address  out  ADDR_WIDTH  read address.
- mem_read_ready  in  1  read response valid; mem_read_data sampled same cycle.
- mem_read_data  in  DATA_WIDTH  read data.
- mem_write_valid  out  1  write request.
- mem_write_address  out  ADDR_WIDTH  write address.
- mem_write_data  out  DATA_WIDTH  write data.
- mem_write_ready  in  1  write acknowledged.
- lsu_state  out  2  IDLE=0, WAITING=1, DONE=2, ERROR=3.
- lsu_waiting  out  1  high while a memory op is outstanding.
- lsu_done  out  1  one-cycle pulse on completion (success or error).
- lsu_error  out  1  sticky until retire: timeout or illegal op.
- lsu_out  out  DATA_WIDTH  last loaded data.

Behaviour:
- Reset (reset==0, async): state IDLE; all outputs 0. Reset mid-op aborts immediately; valids drop without waiting for ready.
- IDLE: when enable and exactly one decoded enable is high, latch rs (and rt for STR), assert the matching mem_*_valid next edge, set lsu_waiting=1, clear the timeout counter, go WAITING. Result: 1-cycle issue latency.
- IDLE, both decoded enables high with enable: no memory request; lsu_error=1, lsu_done pulse, go ERROR.
- IDLE, enable low: stay IDLE, lsu_waiting=0.
- WAITING: hold valid, address and data stable until the matching ready is seen.
  - Read ready: mem_read_valid<=0, lsu_out<=mem_read_data, lsu_waiting<=0, lsu_done pulse, go DONE.
  - Write ready: same, but lsu_out is unchanged.
  - Ready on the non-active channel is ignored.
- WAITING continues regardless of enable or decoded enables dropping. A started transaction always completes or times out.
- Timeout (TIMEOUT_CYCLES>0): counter increments each WAITING cycle without ready. When the count reaches TIMEOUT_CYCLES:
  - drop valid, lsu_waiting=0, lsu_error=1, lsu_done pulse, go ERROR; lsu_out unchanged.
  - Ready arriving on the same cycle as expiry counts as success; ready wins.
- DONE/ERROR: stay until both decoded enables are low (instruction retired), then go IDLE and clear lsu_error. An instruction held high never re-issues.
- lsu_done is high only on the cycle the state enters DONE/ERROR.
- Counter width is $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.

Decomposition:
- Shared package gpu_pkg holds:
  - lsu_state_t enum (IDLE, WAITING, DONE, ERROR);
  - the default width localparams shared with the register file and memory controller.
- No sub-module is required. The timeout counter may optionally be factored as lsu_timeout_ctr (enable, clear, expired).

Test Plan:
- LDR rs=0x3C, memory returns 0xA5 three cycles after valid -> mem_read_valid high exactly 1 cycle after the decode, mem_read_address=0x3C; lsu_out=0xA5; single lsu_done pulse; state DONE until read enable drops, then IDLE.
- STR rs=0x10 rt=0x7E, ready after 1 cycle -> mem_write_address=0x10, mem_write_data=0x7E stable while valid; lsu_out unchanged; lsu_error=0.
- TIMEOUT_CYCLES=4, read with ready never asserted -> valid drops after 4 WAITING cycles; lsu_error=1, state ERROR, done pulse; cleared on retire. Repeat with ready on cycle 4 -> success, no error.
- Read and write decoded together -> no valid asserted; lsu_error=1 next cycle.
- enable=0 with read decoded -> no request, lsu_waiting=0. Drop enable mid-WAITING -> op still completes on ready.
- Assert reset (0) asynchronously mid-WAITING -> all outputs 0 before the next clk edge; after release, a fresh LDR works normally.
- Parameter sweep ADDR_WIDTH=12, DATA_WIDTH=16: rs=0xABC, data 0xBEEF -> full-width address and data observed.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU core types and default widths used by the LSU, register file and memory controller.
package gpu_pkg;

  localparam int unsigned GPU_ADDR_WIDTH = 8;
  localparam int unsigned GPU_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAITING = 2'd1,
    DONE    = 2'd2,
    ERROR   = 2'd3
  } lsu_state_t;

endpackage : gpu_pkg

// File: rtl/lsu_param.sv
// Per-lane load/store unit: issues one LDR/STR to the data-memory controller, with
// optional response timeout, completion strobe and retire handshake.
module lsu_param
  import gpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = GPU_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = GPU_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  decoded_mem_read_enable,
  input  logic                  decoded_mem_write_enable,
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0] rt,
  output logic                  mem_read_valid,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic                  mem_read_ready,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_write_valid,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  mem_write_ready,
  output logic [1:0]            lsu_state,
  output logic                  lsu_waiting,
  output logic                  lsu_done,
  output logic                  lsu_error,
  output logic [DATA_WIDTH-1:0] lsu_out
);

  // A zero timeout still needs a legal (unused) one-bit counter.
  localparam int unsigned CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  lsu_state_t            state_q, state_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  waiting_q, waiting_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  cnt_inc_c;

  // Saturating increment so the counter can never wrap back below the limit.
  assign cnt_inc_c = (cnt_q == CNT_LIMIT) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    rd_valid_d = rd_valid_q;
    wr_valid_d = wr_valid_q;
    addr_d     = addr_q;
    data_d     = data_q;
    out_d      = out_q;
    waiting_d  = waiting_q;
    done_d     = 1'b0;
    error_d    = error_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      IDLE: begin
        waiting_d = 1'b0;
        if (enable) begin
          if (decoded_mem_read_enable && decoded_mem_write_enable) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = ERROR;
          end else if (decoded_mem_read_enable || decoded_mem_write_enable) begin
            addr_d     = rs;
            if (decoded_mem_write_enable) data_d = rt;
            rd_valid_d = decoded_mem_read_enable;
            wr_valid_d = decoded_mem_write_enable;
            waiting_d  = 1'b1;
            cnt_d      = '0;
            state_d    = WAITING;
          end
        end
      end

      // Only the channel we issued on can complete; ready beats a same-cycle expiry.
      WAITING: begin
        if (rd_valid_q && mem_read_ready) begin
          rd_valid_d = 1'b0;
          out_d      = mem_read_data;
          waiting_d  = 1'b0;
          done_d     = 1'b1;
          state_d    = DONE;
        end else if (wr_valid_q && mem_write_ready) begin
          wr_valid_d = 1'b0;
          waiting_d  = 1'b0;
          done_d     = 1'b1;
          state_d    = DONE;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == CNT_LIMIT) begin
            rd_valid_d = 1'b0;
            wr_valid_d = 1'b0;
            waiting_d  = 1'b0;
            error_d    = 1'b1;
            done_d     = 1'b1;
            state_d    = ERROR;
          end
        end
      end

      DONE, ERROR: begin
        if (!decoded_mem_read_enable && !decoded_mem_write_enable) begin
          error_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      out_q      <= '0;
      waiting_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      wr_valid_q <= wr_valid_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      out_q      <= out_d;
      waiting_q  <= waiting_d;
      done_q     <= done_d;
      error_q    <= error_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mem_read_valid    = rd_valid_q;
  assign mem_read_address  = addr_q;
  assign mem_write_valid   = wr_valid_q;
  assign mem_write_address = addr_q;
  assign mem_write_data    = data_q;
  assign lsu_state         = state_q;
  assign lsu_waiting       = waiting_q;
  assign lsu_done          = done_q;
  assign lsu_error         = error_q;
  assign lsu_out           = out_q;

endmodule : lsu_param

// File: tb/tb_lsu_param.sv
// Directed bench for lsu_param: 8-bit lane with a short timeout, plus a 12/16-bit lane.
module tb_lsu_param;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 8-bit lane, TIMEOUT_CYCLES=4
  logic       en8 = 0, dre8 = 0, dwe8 = 0;
  logic [7:0] rs8 = 0, rt8 = 0, rdat8 = 0;
  logic       rrdy8 = 0, wrdy8 = 0;
  logic       rv8, wv8, wait8, done8, err8;
  logic [7:0] ra8, wa8, wd8, out8;
  logic [1:0] st8;

  // 12/16-bit lane, default timeout
  logic        en16 = 0, dre16 = 0, dwe16 = 0;
  logic [11:0] rs16 = 0;
  logic [15:0] rt16 = 0, rdat16 = 0;
  logic        rrdy16 = 0, wrdy16 = 0;
  logic        rv16, wv16, wait16, done16, err16;
  logic [11:0] ra16, wa16;
  logic [15:0] wd16, out16;
  logic [1:0]  st16;

  lsu_param #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT_CYCLES(4)) u_dut8 (
    .clk(clk), .reset(reset), .enable(en8),
    .decoded_mem_read_enable(dre8), .decoded_mem_write_enable(dwe8),
    .rs(rs8), .rt(rt8),
    .mem_read_valid(rv8), .mem_read_address(ra8),
    .mem_read_ready(rrdy8), .mem_read_data(rdat8),
    .mem_write_valid(wv8), .mem_write_address(wa8), .mem_write_data(wd8),
    .mem_write_ready(wrdy8),
    .lsu_state(st8), .lsu_waiting(wait8), .lsu_done(done8),
    .lsu_error(err8), .lsu_out(out8)
  );

  lsu_param #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .enable(en16),
    .decoded_mem_read_enable(dre16), .decoded_mem_write_enable(dwe16),
    .rs(rs16), .rt(rt16),
    .mem_read_valid(rv16), .mem_read_address(ra16),
    .mem_read_ready(rrdy16), .mem_read_data(rdat16),
    .mem_write_valid(wv16), .mem_write_address(wa16), .mem_write_data(wd16),
    .mem_write_ready(wrdy16),
    .lsu_state(st16), .lsu_waiting(wait16), .lsu_done(done16),
    .lsu_error(err16), .lsu_out(out16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    check("rst_state", 32'(st8), 0);
    check("rst_rvalid", 32'(rv8), 0);
    check("rst_out", 32'(out8), 0);
    step();
    reset = 1'b1;
    step();

    // LDR 0x3C, response three cycles after valid
    en8 = 1; dre8 = 1; rs8 = 8'h3C;
    step();
    check("ldr_valid_1cyc", 32'(rv8), 1);
    check("ldr_addr", 32'(ra8), 32'h3C);
    check("ldr_waiting", 32'(wait8), 1);
    check("ldr_state_wait", 32'(st8), 1);
    check("ldr_no_wvalid", 32'(wv8), 0);
    step();
    check("ldr_valid_hold1", 32'(rv8), 1);
    step();
    check("ldr_valid_hold2", 32'(rv8), 1);
    rrdy8 = 1; rdat8 = 8'hA5;
    step();
    rrdy8 = 0; rdat8 = 8'h00;
    check("ldr_out", 32'(out8), 32'hA5);
    check("ldr_done", 32'(done8), 1);
    check("ldr_state_done", 32'(st8), 2);
    check("ldr_valid_drop", 32'(rv8), 0);
    check("ldr_wait_drop", 32'(wait8), 0);
    step();
    check("ldr_done_pulse", 32'(done8), 0);
    check("ldr_hold_done", 32'(st8), 2);
    check("ldr_no_reissue", 32'(rv8), 0);
    dre8 = 0;
    step();
    check("ldr_retire_idle", 32'(st8), 0);

    // STR 0x7E to 0x10, ready one cycle after valid
    dwe8 = 1; rs8 = 8'h10; rt8 = 8'h7E;
    step();
    check("str_valid", 32'(wv8), 1);
    check("str_addr", 32'(wa8), 32'h10);
    check("str_data", 32'(wd8), 32'h7E);
    rs8 = 8'h99; rt8 = 8'h11;
    step();
    check("str_addr_stable", 32'(wa8), 32'h10);
    check("str_data_stable", 32'(wd8), 32'h7E);
    wrdy8 = 1;
    rrdy8 = 1; rdat8 = 8'hEE;
    step();
    wrdy8 = 0; rrdy8 = 0; rdat8 = 0;
    check("str_done", 32'(done8), 1);
    check("str_state", 32'(st8), 2);
    check("str_out_keep", 32'(out8), 32'hA5);
    check("str_no_err", 32'(err8), 0);
    check("str_wvalid_drop", 32'(wv8), 0);
    dwe8 = 0;
    step();
    check("str_retire", 32'(st8), 0);

    // Read timeout after 4 WAITING cycles
    dre8 = 1; rs8 = 8'h55;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("to_valid_%0d", i), 32'(rv8), 1);
    end
    step();
    check("to_valid_drop", 32'(rv8), 0);
    check("to_err", 32'(err8), 1);
    check("to_state", 32'(st8), 3);
    check("to_done", 32'(done8), 1);
    check("to_wait", 32'(wait8), 0);
    check("to_out_keep", 32'(out8), 32'hA5);
    step();
    check("to_done_pulse", 32'(done8), 0);
    check("to_err_sticky", 32'(err8), 1);
    dre8 = 0;
    step();
    check("to_retire_state", 32'(st8), 0);
    check("to_retire_err", 32'(err8), 0);

    // Ready on the expiry cycle wins
    dre8 = 1; rs8 = 8'h56;
    for (int i = 0; i < 4; i++) step();
    check("race_valid", 32'(rv8), 1);
    rrdy8 = 1; rdat8 = 8'h5A;
    step();
    rrdy8 = 0;
    check("race_state", 32'(st8), 2);
    check("race_err", 32'(err8), 0);
    check("race_out", 32'(out8), 32'h5A);
    dre8 = 0;
    step();

    // Both decoded: illegal, no request
    dre8 = 1; dwe8 = 1;
    step();
    check("ill_rvalid", 32'(rv8), 0);
    check("ill_wvalid", 32'(wv8), 0);
    check("ill_err", 32'(err8), 1);
    check("ill_state", 32'(st8), 3);
    check("ill_done", 32'(done8), 1);
    dre8 = 0; dwe8 = 0;
    step();
    check("ill_retire", 32'(err8), 0);

    // Inactive lane never starts
    en8 = 0; dre8 = 1; rs8 = 8'h20;
    step();
    check("dis_rvalid", 32'(rv8), 0);
    check("dis_waiting", 32'(wait8), 0);
    check("dis_state", 32'(st8), 0);
    // Enable dropped mid-WAITING: op still completes
    en8 = 1;
    step();
    check("drop_valid", 32'(rv8), 1);
    en8 = 0; dre8 = 0;
    step();
    check("drop_still_wait", 32'(st8), 1);
    rrdy8 = 1; rdat8 = 8'h33;
    step();
    rrdy8 = 0;
    check("drop_done", 32'(st8), 2);
    check("drop_out", 32'(out8), 32'h33);
    step();
    check("drop_idle", 32'(st8), 0);

    // Asynchronous reset mid-WAITING
    en8 = 1; dre8 = 1; rs8 = 8'h44;
    step();
    check("ar_pre_valid", 32'(rv8), 1);
    #2 reset = 1'b0;
    #1;
    check("ar_rvalid", 32'(rv8), 0);
    check("ar_waiting", 32'(wait8), 0);
    check("ar_state", 32'(st8), 0);
    check("ar_out", 32'(out8), 0);
    check("ar_addr", 32'(ra8), 0);
    dre8 = 0;
    #2 reset = 1'b1;
    step();
    dre8 = 1; rs8 = 8'h77;
    step();
    check("ar_fresh_valid", 32'(rv8), 1);
    check("ar_fresh_addr", 32'(ra8), 32'h77);
    rrdy8 = 1; rdat8 = 8'h99;
    step();
    rrdy8 = 0;
    check("ar_fresh_out", 32'(out8), 32'h99);
    check("ar_fresh_state", 32'(st8), 2);
    dre8 = 0;

    // Wide lane: 12-bit address, 16-bit data
    en16 = 1; dre16 = 1; rs16 = 12'hABC;
    step();
    check("w_raddr", 32'(ra16), 32'hABC);
    check("w_rvalid", 32'(rv16), 1);
    rrdy16 = 1; rdat16 = 16'hBEEF;
    step();
    rrdy16 = 0;
    check("w_out", 32'(out16), 32'hBEEF);
    check("w_done", 32'(done16), 1);
    dre16 = 0;
    step();
    dwe16 = 1; rs16 = 12'hF0A; rt16 = 16'hC0DE;
    step();
    check("w_waddr", 32'(wa16), 32'hF0A);
    check("w_wdata", 32'(wd16), 32'hC0DE);
    wrdy16 = 1;
    step();
    wrdy16 = 0;
    check("w_str_state", 32'(st16), 2);
    check("w_str_out_keep", 32'(out16), 32'hBEEF);
    dwe16 = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_lsu_param
